// File: rtl/sdram_arbiter.sv
// sdram_arbiter: registered, transaction-locked arbiter between NUM_PORTS
// cores and a single SDRAM bus master. Fixed-select or round-robin.

// Per-port eligibility and conflict detect.
module sdram_arbiter_port (
  input  logic req_rd,
  input  logic req_wr,
  input  logic masked,
  input  logic sel_ok,
  output logic elig,
  output logic conflict
);
  assign elig     = (req_rd | req_wr) & ~masked & sel_ok;
  assign conflict = req_rd & req_wr;
endmodule

module sdram_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = 1,
  localparam int SEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [SEL_W-1:0]            i_mode_sel,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_PORTS-1:0]        req_finished,
  output logic                        sdram_read,
  output logic                        sdram_write,
  output logic [ADDR_W-1:0]           sdram_addr,
  output logic [DATA_W-1:0]           sdram_writedata,
  input  logic [DATA_W-1:0]           sdram_readdata,
  input  logic                        sdram_finished,
  output logic [NUM_PORTS-1:0]        o_grant,
  output logic                        o_busy,
  output logic                        o_err
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t                          state, state_d;
  logic [SEL_W-1:0]                last_grant, last_d;
  logic [NUM_PORTS-1:0]            mask_oh, mask_d;
  logic [NUM_PORTS-1:0]            elig, conflict, sel_ok;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_arr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_arr;

  logic [NUM_PORTS-1:0] grant_d, fin_d;
  logic                 rd_d, wr_d, err_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d, rdata_d;
  logic                 found;
  logic [SEL_W-1:0]     win_idx;

  assign addr_arr  = req_addr;
  assign wdata_arr = req_writedata;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    // In fixed mode only the selected port may compete.
    assign sel_ok[k] = (ARB_MODE != 0) || (i_mode_sel == SEL_W'(k));
    sdram_arbiter_port u_port (
      .req_rd   (req_read[k]),
      .req_wr   (req_write[k]),
      .masked   (mask_oh[k]),
      .sel_ok   (sel_ok[k]),
      .elig     (elig[k]),
      .conflict (conflict[k])
    );
  end

  // Next-state and next-output computation; all outputs are registered below.
  always_comb begin
    int idx;
    state_d = state;
    last_d  = last_grant;
    mask_d  = '0;
    grant_d = o_grant;
    fin_d   = '0;
    rd_d    = sdram_read;
    wr_d    = sdram_write;
    addr_d  = sdram_addr;
    wdata_d = sdram_writedata;
    rdata_d = req_readdata;
    err_d   = o_err | (|conflict);
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    case (state)
      IDLE: begin
        // Rotating search starting just after the previous winner.
        for (int i = 1; i <= NUM_PORTS; i++) begin
          idx = (int'(last_grant) + i) % NUM_PORTS;
          if (!found && elig[idx]) begin
            found   = 1'b1;
            win_idx = SEL_W'(idx);
          end
        end
        if (found) begin
          state_d          = BUSY;
          last_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          addr_d           = addr_arr[win_idx];
          wdata_d          = wdata_arr[win_idx];
          // Read+write together is treated as a write.
          wr_d             = req_write[win_idx];
          rd_d             = req_read[win_idx] & ~req_write[win_idx];
        end
      end
      BUSY: begin
        if (sdram_finished) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (sdram_read) rdata_d = sdram_readdata;
          fin_d   = o_grant;
          mask_d  = o_grant;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      last_grant      <= SEL_W'(NUM_PORTS - 1);
      mask_oh         <= '0;
      o_grant         <= '0;
      req_finished    <= '0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
      req_readdata    <= '0;
      o_busy          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      state           <= state_d;
      last_grant      <= last_d;
      mask_oh         <= mask_d;
      o_grant         <= grant_d;
      req_finished    <= fin_d;
      sdram_read      <= rd_d;
      sdram_write     <= wr_d;
      sdram_addr      <= addr_d;
      sdram_writedata <= wdata_d;
      req_readdata    <= rdata_d;
      o_busy          <= (state_d == BUSY);
      o_err           <= err_d;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench: round-robin instance (r_*) and fixed-select instance (f_*).
module tb_sdram_arbiter;
  localparam int NP = 5;
  localparam int AW = 23;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Round-robin DUT signals
  logic [2:0]       r_sel;
  logic [NP-1:0]    r_rd, r_wr, r_fin_o, r_grant;
  logic [NP*AW-1:0] r_addr;
  logic [NP*DW-1:0] r_wdata;
  logic [DW-1:0]    r_rdata_o, r_bus_rdata, r_bus_wdata;
  logic [AW-1:0]    r_bus_addr;
  logic             r_bus_rd, r_bus_wr, r_fin, r_busy, r_err;

  // Fixed-select DUT signals
  logic [2:0]       f_sel;
  logic [NP-1:0]    f_rd, f_wr, f_fin_o, f_grant;
  logic [NP*AW-1:0] f_addr;
  logic [NP*DW-1:0] f_wdata;
  logic [DW-1:0]    f_rdata_o, f_bus_rdata, f_bus_wdata;
  logic [AW-1:0]    f_bus_addr;
  logic             f_bus_rd, f_bus_wr, f_fin, f_busy, f_err;

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_rr (
    .i_clk(clk), .i_rst(rst), .i_mode_sel(r_sel),
    .req_read(r_rd), .req_write(r_wr), .req_addr(r_addr), .req_writedata(r_wdata),
    .req_readdata(r_rdata_o), .req_finished(r_fin_o),
    .sdram_read(r_bus_rd), .sdram_write(r_bus_wr), .sdram_addr(r_bus_addr),
    .sdram_writedata(r_bus_wdata), .sdram_readdata(r_bus_rdata), .sdram_finished(r_fin),
    .o_grant(r_grant), .o_busy(r_busy), .o_err(r_err)
  );

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut_fx (
    .i_clk(clk), .i_rst(rst), .i_mode_sel(f_sel),
    .req_read(f_rd), .req_write(f_wr), .req_addr(f_addr), .req_writedata(f_wdata),
    .req_readdata(f_rdata_o), .req_finished(f_fin_o),
    .sdram_read(f_bus_rd), .sdram_write(f_bus_wr), .sdram_addr(f_bus_addr),
    .sdram_writedata(f_bus_wdata), .sdram_readdata(f_bus_rdata), .sdram_finished(f_fin),
    .o_grant(f_grant), .o_busy(f_busy), .o_err(f_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int order [6];
    order = '{0, 1, 4, 0, 1, 4};
    rst = 1'b1;
    r_sel = '0; r_rd = '0; r_wr = '0; r_addr = '0; r_wdata = '0; r_bus_rdata = '0; r_fin = 1'b0;
    f_sel = 3'd3; f_rd = '0; f_wr = '0; f_addr = '0; f_wdata = '0; f_bus_rdata = '0; f_fin = 1'b0;
    tick(); tick();
    chk("rst_grant", r_grant, 0);
    chk("rst_rd", r_bus_rd, 0);
    chk("rst_wr", r_bus_wr, 0);
    chk("rst_fin", r_fin_o, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_err", r_err, 0);
    chk("rst_rdata", r_rdata_o, 0);
    rst = 1'b0;

    // Single read on port 2, bus latency 4
    r_addr[2*AW +: AW] = 23'h000123;
    r_rd[2] = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (r_bus_rd === 1'b1) cnt++;
      chk("rd_addr", r_bus_addr, 23'h000123);
      chk("rd_grant", r_grant, 5'b00100);
      if (c == 4) begin r_fin = 1'b1; r_bus_rdata = 32'hDEADBEEF; end
    end
    tick();
    r_fin = 1'b0; r_rd[2] = 1'b0;
    chk("rd_strobe_cycles", cnt, 4);
    chk("rd_strobe_off", r_bus_rd, 0);
    chk("rd_fin_pulse", r_fin_o, 5'b00100);
    chk("rd_data", r_rdata_o, 32'hDEADBEEF);
    chk("rd_grant_idle", r_grant, 0);
    tick();
    chk("rd_fin_one_cycle", r_fin_o, 0);

    // sdram_finished while idle is ignored
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0;
    chk("idle_fin_busy", r_busy, 0);
    tick();
    chk("idle_fin_pulse", r_fin_o, 0);
    chk("idle_fin_rdata", r_rdata_o, 32'hDEADBEEF);

    // Round-robin fairness: ports 0,1,4 write continuously, latency 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NP; k++) begin
      r_addr[k*AW +: AW]  = AW'(32'h100 + k);
      r_wdata[k*DW +: DW] = 32'hA000_0000 + k;
    end
    r_wr = 5'b10011;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("rr_grant", r_grant, 64'(1) << order[t]);
      chk("rr_wr", r_bus_wr, 1);
      chk("rr_addr", r_bus_addr, 64'h100 + order[t]);
      chk("rr_wdata", r_bus_wdata, 64'hA000_0000 + order[t]);
      tick();
      chk("rr_wr_hold", r_bus_wr, 1);
      r_fin = 1'b1;
      tick();
      r_fin = 1'b0;
      if (t == 5) r_wr = '0;
      chk("rr_gap", r_bus_wr, 0);
      chk("rr_fin", r_fin_o, 64'(1) << order[t]);
    end
    tick();
    chk("rr_done_idle", r_busy, 0);

    // Sticky request held only through the pulse cycle: no regrant
    r_rd[0] = 1'b1;
    tick();
    chk("st_grant", r_grant, 5'b00001);
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0;
    chk("st_pulse", r_fin_o, 5'b00001);
    tick();
    chk("st_masked", r_grant, 0);
    r_rd[0] = 1'b0;
    tick();
    chk("st_no_regrant", r_grant, 0);
    // Held for two cycles past the pulse: regranted
    r_rd[0] = 1'b1;
    tick();
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0;
    chk("st2_pulse", r_fin_o, 5'b00001);
    tick();
    chk("st2_masked", r_grant, 0);
    tick();
    chk("st2_regrant", r_grant, 5'b00001);
    chk("st2_rd", r_bus_rd, 1);
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0; r_rd[0] = 1'b0;
    chk("st2_pulse2", r_fin_o, 5'b00001);
    tick();

    // Read+write conflict on port 1
    r_wdata[1*DW +: DW] = 32'h00000055;
    r_rd[1] = 1'b1; r_wr[1] = 1'b1;
    tick();
    chk("cf_grant", r_grant, 5'b00010);
    chk("cf_wr", r_bus_wr, 1);
    chk("cf_rd", r_bus_rd, 0);
    chk("cf_wdata", r_bus_wdata, 32'h00000055);
    chk("cf_err", r_err, 1);
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0; r_rd[1] = 1'b0; r_wr[1] = 1'b0;
    chk("cf_pulse", r_fin_o, 5'b00010);
    tick(); tick();
    chk("cf_err_sticky", r_err, 1);

    // Reset during a read on port 3
    r_rd[3] = 1'b1;
    tick();
    chk("rb_grant", r_grant, 5'b01000);
    rst = 1'b1;
    tick();
    chk("rb_rd", r_bus_rd, 0);
    chk("rb_grant_clr", r_grant, 0);
    chk("rb_fin", r_fin_o, 0);
    chk("rb_err_clr", r_err, 0);
    rst = 1'b0;
    r_rd[0] = 1'b1;
    tick();
    chk("rb_prio0", r_grant, 5'b00001);
    r_fin = 1'b1;
    tick();
    r_fin = 1'b0; r_rd = '0;
    chk("rb_pulse", r_fin_o, 5'b00001);
    tick();

    // Fixed-select mode: sel=3, port 1 alone is ignored
    f_wr[1] = 1'b1;
    tick(); tick();
    chk("fx_ignore", f_grant, 0);
    chk("fx_ignore_busy", f_busy, 0);
    f_rd[3] = 1'b1;
    tick();
    chk("fx_grant3", f_grant, 5'b01000);
    chk("fx_rd3", f_bus_rd, 1);
    f_sel = 3'd1;
    tick();
    chk("fx_hold3", f_grant, 5'b01000);
    f_fin = 1'b1;
    tick();
    f_fin = 1'b0; f_rd[3] = 1'b0;
    chk("fx_pulse3", f_fin_o, 5'b01000);
    tick();
    chk("fx_grant1", f_grant, 5'b00010);
    chk("fx_wr1", f_bus_wr, 1);
    f_fin = 1'b1;
    tick();
    f_fin = 1'b0; f_wr[1] = 1'b0;
    chk("fx_pulse1", f_fin_o, 5'b00010);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
